// File: rtl/alu_reduce_if.sv
// Handshake bundle between the ALU operand mux and the segmented-reduction unit.
// The unit sits on the slave side; the operand mux and writeback arbiter act as master.
interface alu_reduce_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] din;
    logic [2:0]        funct;
    logic [1:0]        op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] res;
    logic              err;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output in_valid, din, funct, op, out_ready,
        input  in_ready, out_valid, res, err, err_cnt
    );

    modport slave (
        input  in_valid, din, funct, op, out_ready,
        output in_ready, out_valid, res, err, err_cnt
    );
endinterface

// File: rtl/alu_reduce_pipe.sv
// Two-stage segmented OR/AND/XOR reducer with valid/ready backpressure,
// illegal-op flagging and a saturating illegal-transaction counter.
module alu_reduce_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_reduce_if.slave  bus
);
    localparam int unsigned NIB  = DATA_W / 4;
    localparam int unsigned LOG2 = $clog2(DATA_W);
    localparam logic [1:0]  OP_AND = 2'd1;
    localparam logic [1:0]  OP_XOR = 2'd2;
    localparam logic [1:0]  OP_ILL = 2'd3;
    localparam logic [DATA_W-1:0] ILL_RES = {(DATA_W/32){32'hDEAD_BEEF}};

    function automatic logic red2(input logic a, input logic b, input logic [1:0] o);
        case (o)
            OP_AND:  red2 = a & b;
            OP_XOR:  red2 = a ^ b;
            default: red2 = a | b;
        endcase
    endfunction

    logic              s1_v_q, s1_v_d;
    logic [NIB-1:0]    s1_or_q, s1_or_d;
    logic [NIB-1:0]    s1_and_q, s1_and_d;
    logic [NIB-1:0]    s1_xor_q, s1_xor_d;
    logic [DATA_W-1:0] s1_din_q, s1_din_d;
    logic [2:0]        s1_funct_q, s1_funct_d;
    logic [1:0]        s1_op_q, s1_op_d;
    logic              s1_legal_q, s1_legal_d;
    logic              s2_v_q, s2_v_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic              s2_adv_c, s1_adv_c, accept_c, legal_in_c;
    logic [NIB-1:0]    or_in_c, and_in_c, xor_in_c;
    logic [DATA_W-1:0] red_res_c;
    logic [NIB-1:0]    cur_c, nxt_c;

    assign s2_adv_c   = !s2_v_q || bus.out_ready;
    assign s1_adv_c   = !s1_v_q || s2_adv_c;
    assign accept_c   = bus.in_valid && s1_adv_c;
    assign legal_in_c = (bus.op != OP_ILL) && (32'(bus.funct) <= LOG2);

    assign bus.in_ready  = s1_adv_c;
    assign bus.out_valid = s2_v_q;
    assign bus.res       = res_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;

    // Per-nibble partial reductions for all three ops, captured in S1.
    always_comb begin
        or_in_c  = '0;
        and_in_c = '0;
        xor_in_c = '0;
        for (int k = 0; k < int'(NIB); k++) begin
            or_in_c[k]  = |bus.din[4*k +: 4];
            and_in_c[k] = &bus.din[4*k +: 4];
            xor_in_c[k] = ^bus.din[4*k +: 4];
        end
    end

    // S2 combine: S=1/S=2 work from the raw operand, S>=4 fold the nibble partials pairwise.
    always_comb begin
        red_res_c = '0;
        nxt_c     = '0;
        case (s1_op_q)
            OP_AND:  cur_c = s1_and_q;
            OP_XOR:  cur_c = s1_xor_q;
            default: cur_c = s1_or_q;
        endcase
        case (s1_funct_q)
            3'd0: red_res_c = s1_din_q;
            3'd1: begin
                for (int i = 0; i < int'(DATA_W / 2); i++)
                    red_res_c[2*i] = red2(s1_din_q[2*i], s1_din_q[2*i+1], s1_op_q);
            end
            default: begin
                if (s1_funct_q == 3'd2) begin
                    for (int i = 0; i < int'(NIB); i++)
                        red_res_c[4*i] = cur_c[i];
                end
                for (int lvl = 3; lvl <= int'(LOG2); lvl++) begin
                    nxt_c = '0;
                    for (int j = 0; j < int'(NIB / 2); j++)
                        nxt_c[j] = red2(cur_c[2*j], cur_c[2*j+1], s1_op_q);
                    cur_c = nxt_c;
                    if (s1_funct_q == 3'(lvl)) begin
                        for (int j = 0; j < int'(NIB); j++)
                            if ((j << lvl) < int'(DATA_W))
                                red_res_c[j << lvl] = cur_c[j];
                    end
                end
            end
        endcase
    end

    // Next-state for both stages and the illegal-op counter.
    always_comb begin
        s1_v_d     = s1_v_q;
        s1_or_d    = s1_or_q;
        s1_and_d   = s1_and_q;
        s1_xor_d   = s1_xor_q;
        s1_din_d   = s1_din_q;
        s1_funct_d = s1_funct_q;
        s1_op_d    = s1_op_q;
        s1_legal_d = s1_legal_q;
        s2_v_d     = s2_v_q;
        res_d      = res_q;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;

        if (s1_adv_c) begin
            s1_v_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_or_d    = or_in_c;
                s1_and_d   = and_in_c;
                s1_xor_d   = xor_in_c;
                s1_din_d   = bus.din;
                s1_funct_d = bus.funct;
                s1_op_d    = bus.op;
                s1_legal_d = legal_in_c;
            end
        end

        if (s2_adv_c) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                res_d = s1_legal_q ? red_res_c : ILL_RES;
                err_d = !s1_legal_q;
            end
        end

        if (accept_c && !legal_in_c && (err_cnt_q != {CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_or_q    <= '0;
            s1_and_q   <= '0;
            s1_xor_q   <= '0;
            s1_din_q   <= '0;
            s1_funct_q <= '0;
            s1_op_q    <= '0;
            s1_legal_q <= 1'b0;
            s2_v_q     <= 1'b0;
            res_q      <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_or_q    <= s1_or_d;
            s1_and_q   <= s1_and_d;
            s1_xor_q   <= s1_xor_d;
            s1_din_q   <= s1_din_d;
            s1_funct_q <= s1_funct_d;
            s1_op_q    <= s1_op_d;
            s1_legal_q <= s1_legal_d;
            s2_v_q     <= s2_v_d;
            res_q      <= res_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_reduce_pipe.sv
// Directed and randomised checks of alu_reduce_pipe at DATA_W=32, with a second
// CNT_W=2 instance sharing the same stimulus to exercise counter saturation.
module tb_alu_reduce_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_reduce_if #(.DATA_W(32), .CNT_W(16)) bus ();
    alu_reduce_if #(.DATA_W(32), .CNT_W(2))  bus_s ();

    alu_reduce_pipe #(.DATA_W(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    alu_reduce_pipe #(.DATA_W(32), .CNT_W(2))  dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus_s.slave));

    assign bus_s.in_valid  = bus.in_valid;
    assign bus_s.din       = bus.din;
    assign bus_s.funct     = bus.funct;
    assign bus_s.op        = bus.op;
    assign bus_s.out_ready = bus.out_ready;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bit-by-bit reference reduction, independent of the nibble-tree structure.
    function automatic logic [31:0] ref_res(input logic [31:0] d, input logic [2:0] f,
                                            input logic [1:0] o, output logic e);
        logic [31:0] r;
        logic        acc;
        int          s;
        if (o == 2'd3 || f > 3'd5) begin
            e = 1'b1;
            return 32'hDEAD_BEEF;
        end
        e = 1'b0;
        r = '0;
        s = 1 << f;
        for (int i = 0; i < 32; i += s) begin
            acc = (o == 2'd1);
            for (int b = 0; b < s; b++) begin
                case (o)
                    2'd1:    acc = acc & d[i+b];
                    2'd2:    acc = acc ^ d[i+b];
                    default: acc = acc | d[i+b];
                endcase
            end
            r[i] = acc;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] f,
                         input logic [1:0] o, input logic rdy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.din       = d;
        bus.funct     = f;
        bus.op        = o;
        bus.out_ready = rdy;
    endtask

    // One beat with out_ready high: checks accept, 2-cycle latency, result and both counters.
    task automatic send_chk(input string tag, input logic [31:0] d, input logic [2:0] f,
                            input logic [1:0] o, input logic [31:0] exp_res, input logic exp_err,
                            input logic [15:0] exp_cnt, input logic [1:0] exp_scnt);
        drive(1'b1, d, f, o, 1'b1);
        #1 check({tag, ":in_ready"}, 64'(bus.in_ready), 64'(1));
        drive(1'b0, '0, '0, '0, 1'b1);
        #1;
        check({tag, ":early_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, ":err_cnt"}, 64'(bus.err_cnt), 64'(exp_cnt));
        check({tag, ":sat_cnt"}, 64'(bus_s.err_cnt), 64'(exp_scnt));
        @(negedge clk);
        #1;
        check({tag, ":out_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, ":res"}, 64'(bus.res), 64'(exp_res));
        check({tag, ":err"}, 64'(bus.err), 64'(exp_err));
    endtask

    initial begin
        logic [31:0] q_res[$];
        logic        q_err[$];
        logic [31:0] er;
        logic        ee;
        logic [15:0] cnt0;
        logic        pend;
        int          acc_n, ill_n, cycles;

        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.funct     = '0;
        bus.op        = '0;
        bus.out_ready = 1'b0;

        #1;
        check("rst:out_valid", 64'(bus.out_valid), 64'(0));
        check("rst:res", 64'(bus.res), 64'(0));
        check("rst:err", 64'(bus.err), 64'(0));
        check("rst:err_cnt", 64'(bus.err_cnt), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 check("rel:in_ready", 64'(bus.in_ready), 64'(1));

        send_chk("or_f2",   32'h0000_F010, 3'd2, 2'd0, 32'h0000_1010, 1'b0, 16'd0, 2'd0);
        send_chk("and_f3",  32'hFF7F_FF00, 3'd3, 2'd1, 32'h0100_0100, 1'b0, 16'd0, 2'd0);
        send_chk("xor_f5",  32'h0000_0007, 3'd5, 2'd2, 32'h0000_0001, 1'b0, 16'd0, 2'd0);
        send_chk("xor_f0",  32'hA5A5_1234, 3'd0, 2'd2, 32'hA5A5_1234, 1'b0, 16'd0, 2'd0);
        send_chk("and_f1",  32'hC000_000F, 3'd1, 2'd1, 32'h4000_0005, 1'b0, 16'd0, 2'd0);
        send_chk("xor_f4",  32'h0001_0003, 3'd4, 2'd2, 32'h0001_0000, 1'b0, 16'd0, 2'd0);
        send_chk("ill_f6",  32'h1234_5678, 3'd6, 2'd0, 32'hDEAD_BEEF, 1'b1, 16'd1, 2'd1);
        send_chk("ill_op3", 32'h1234_5678, 3'd1, 2'd3, 32'hDEAD_BEEF, 1'b1, 16'd2, 2'd2);
        send_chk("ill_f7",  32'hFFFF_FFFF, 3'd7, 2'd2, 32'hDEAD_BEEF, 1'b1, 16'd3, 2'd3);
        send_chk("ill_4",   32'h0000_0000, 3'd0, 2'd3, 32'hDEAD_BEEF, 1'b1, 16'd4, 2'd3);
        send_chk("ill_5",   32'h0F0F_0F0F, 3'd2, 2'd3, 32'hDEAD_BEEF, 1'b1, 16'd5, 2'd3);

        // Backpressure: three beats against a stalled output.
        drive(1'b1, 32'h0000_F010, 3'd2, 2'd0, 1'b0);
        #1 check("bp:acc_a", 64'(bus.in_ready), 64'(1));
        drive(1'b1, 32'hFF7F_FF00, 3'd3, 2'd1, 1'b0);
        #1 check("bp:acc_b", 64'(bus.in_ready), 64'(1));
        drive(1'b1, 32'h1234_5678, 3'd0, 2'd2, 1'b0);
        #1;
        check("bp:full", 64'(bus.in_ready), 64'(0));
        check("bp:valid_a", 64'(bus.out_valid), 64'(1));
        check("bp:res_a", 64'(bus.res), 64'(32'h0000_1010));
        @(negedge clk);
        #1;
        check("bp:still_full", 64'(bus.in_ready), 64'(0));
        check("bp:res_hold", 64'(bus.res), 64'(32'h0000_1010));
        bus.out_ready = 1'b1;
        #1;
        check("bp:reopen", 64'(bus.in_ready), 64'(1));
        check("bp:drain_a", 64'(bus.res), 64'(32'h0000_1010));
        drive(1'b0, '0, '0, '0, 1'b1);
        #1;
        check("bp:valid_b", 64'(bus.out_valid), 64'(1));
        check("bp:drain_b", 64'(bus.res), 64'(32'h0100_0100));
        @(negedge clk);
        #1;
        check("bp:valid_c", 64'(bus.out_valid), 64'(1));
        check("bp:drain_c", 64'(bus.res), 64'(32'h1234_5678));
        @(negedge clk);
        #1 check("bp:empty", 64'(bus.out_valid), 64'(0));

        // Random stream with random backpressure against the reference model.
        cnt0   = bus.err_cnt;
        pend   = 1'b0;
        acc_n  = 0;
        ill_n  = 0;
        cycles = 0;
        while ((acc_n < 100 || q_res.size() > 0) && cycles < 3000) begin
            @(negedge clk);
            if (!pend) begin
                if (acc_n < 100 && $urandom_range(0, 7) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.din      = $urandom;
                    bus.funct    = 3'($urandom_range(0, 7));
                    bus.op       = 2'($urandom_range(0, 3));
                    pend         = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (q_res.size() == 0) begin
                    check("rnd:extra", 64'(1), 64'(0));
                end else begin
                    check("rnd:res", 64'(bus.res), 64'(q_res.pop_front()));
                    check("rnd:err", 64'(bus.err), 64'(q_err.pop_front()));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                er = ref_res(bus.din, bus.funct, bus.op, ee);
                q_res.push_back(er);
                q_err.push_back(ee);
                acc_n++;
                if (ee) ill_n++;
                pend = 1'b0;
            end
            cycles++;
        end
        bus.in_valid = 1'b0;
        check("rnd:completed", 64'(acc_n == 100 && q_res.size() == 0), 64'(1));
        check("rnd:err_cnt", 64'(16'(bus.err_cnt - cnt0)), 64'(ill_n));

        // Reset with both stages occupied.
        drive(1'b1, 32'h0, 3'd7, 2'd0, 1'b0);
        drive(1'b1, 32'h0, 3'd1, 2'd3, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0);
        #1;
        check("mid:full", 64'(bus.in_ready), 64'(0));
        check("mid:err_pre", 64'(bus.err), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("mid:out_valid", 64'(bus.out_valid), 64'(0));
        check("mid:err", 64'(bus.err), 64'(0));
        check("mid:err_cnt", 64'(bus.err_cnt), 64'(0));
        check("mid:sat_cnt", 64'(bus_s.err_cnt), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("mid:in_ready", 64'(bus.in_ready), 64'(1));
        check("mid:no_ghost", 64'(bus.out_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
